scan_bist_controller: RTL and testbench
=======================================

Name: scan_bist_controller

Overview:
- Sequencer for the test-per-scan BIST datapath (PRPG LFSR, CUT scan chain, MISR).
- Runs N_PATTERNS shift/capture rounds, then flushes the chain into the MISR.
- Compares the final MISR signature against a golden value and reports bist_end/pass_nfail to the top level.
- Sits between top-level BIST pins and the PRPG/MISR/CUT control inputs.

Parameters:
- SCAN_LEN, 16, scan chain length in flops (>=2).
- N_PATTERNS, 1000, number of pseudo-random patterns applied (>=1).
- SIG_WIDTH, 16, MISR signature width.
- GOLDEN_SIG, 16'h0000, expected fault-free signature (SIG_WIDTH bits).

Ports:
- clock, in, 1, system clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- bist_start, in, 1, level request to run BIST.
- misr_sig, in, SIG_WIDTH, current MISR contents.
- prpg_load, out, 1, load seed into PRPG.
- misr_clear, out, 1, clear MISR.
- lfsr_en, out, 1, advance PRPG one step.
- misr_en, out, 1, compact the scan-out bit into the MISR.
- scan_en, out, 1, CUT scan shift mode.
- capture_en, out, 1, CUT functional capture clock enable.
- bist_mode, out, 1, steer CUT inputs from PRPG; high in every state except IDLE and DONE.
- bist_busy, out, 1, run in progress.
- bist_end, out, 1, run complete (held).
- pass_nfail, out, 1, 1 = signature matched; valid while bist_end=1.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, both counters 0, all outputs 0.
- Outputs are decoded from registered state (Moore); no combinational path from inputs to outputs.
- FSM states: IDLE, INIT, SHIFT, CAPTURE, FLUSH, COMPARE, DONE.
- IDLE: bist_start=1 -> INIT.
- INIT (1 cycle): prpg_load=1, misr_clear=1; clear shift counter and pattern counter; -> SHIFT.
- SHIFT (SCAN_LEN cycles): scan_en=1, lfsr_en=1.
  - misr_en=1 only when pattern counter != 0; the first shift unloads unknown chain contents.
  - After the SCAN_LEN-th cycle -> CAPTURE.
- CAPTURE (1 cycle): capture_en=1, scan_en=0; increment pattern counter.
  - -> SHIFT if the counter value was < N_PATTERNS-1, else -> FLUSH.
- FLUSH (SCAN_LEN cycles): scan_en=1, misr_en=1, lfsr_en=0; -> COMPARE.
- COMPARE (1 cycle): register pass_nfail <= (misr_sig == GOLDEN_SIG); -> DONE.
- DONE: bist_end=1, pass_nfail held, bist_busy=0; -> IDLE only when bist_start=0.
  - A held-high bist_start does not retrigger a run.
  - On exit to IDLE, bist_end and pass_nfail are cleared.
- bist_busy=1 in INIT through COMPARE.
- bist_start deasserting mid-run is ignored; the run completes.
- Latency: bist_end rises at edge 1 + N_PATTERNS*(SCAN_LEN+1) + SCAN_LEN + 1 after the edge that samples bist_start=1 in IDLE.
- Counter widths: shift counter $clog2(SCAN_LEN) bits; pattern counter $clog2(N_PATTERNS+1) bits.
  - Counters never wrap inside a run; compares use SCAN_LEN-1 and N_PATTERNS-1.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0; no partial result reported.

Optional Feature:
- Macro: BIST_ABORT_EN.
- Defined: adds input bist_abort (1 bit).
  - bist_abort=1 in any of INIT..COMPARE -> DONE next edge with pass_nfail=0, bist_end=1.
  - Abort has priority over all other transitions, including COMPARE.
- Undefined: no port; the run always completes.

Test Plan:
- Bench parameters SCAN_LEN=4, N_PATTERNS=3, GOLDEN_SIG=16'hA5C3; all scenarios use these.
- Nominal run: reset, bist_start=1, misr_sig=16'hA5C3 -> bist_end rises 21 edges after start sampled, pass_nfail=1, bist_end held while bist_start=1.
- Fail: same run with misr_sig=16'hA5C2 -> bist_end=1, pass_nfail=0.
- Control sequence check:
  - prpg_load/misr_clear high exactly 1 cycle.
  - scan_en high 4 cycles x3 plus 4 flush cycles.
  - capture_en pulses exactly 3 times.
  - misr_en low during the first shift, high for the 12 cycles after it.
- Retrigger: hold bist_start=1 in DONE for 50 cycles -> no new INIT. Drop bist_start -> IDLE, bist_end=0. Raise again -> full second run of 21 edges.
- Reset mid-run: assert reset during the second SHIFT -> all outputs 0 immediately; fresh start completes normally.
- With BIST_ABORT_EN: pulse bist_abort in CAPTURE of pattern 1 -> next edge bist_end=1, pass_nfail=0.

Source files
------------

// File: rtl/scan_bist_controller.sv
// Sequencer for a test-per-scan BIST datapath: PRPG seeding, shift/capture rounds, MISR flush and signature check.
// Define BIST_ABORT_EN to add the bist_abort input, which ends a run early with a fail result.
module scan_bist_controller #(
  parameter int                   SCAN_LEN   = 16,
  parameter int                   N_PATTERNS = 1000,
  parameter int                   SIG_WIDTH  = 16,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bist_start,
`ifdef BIST_ABORT_EN
  input  logic                 bist_abort,
`endif
  input  logic [SIG_WIDTH-1:0] misr_sig,
  output logic                 prpg_load,
  output logic                 misr_clear,
  output logic                 lfsr_en,
  output logic                 misr_en,
  output logic                 scan_en,
  output logic                 capture_en,
  output logic                 bist_mode,
  output logic                 bist_busy,
  output logic                 bist_end,
  output logic                 pass_nfail
);

  localparam int SH_W = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam int PC_W = (N_PATTERNS > 0) ? $clog2(N_PATTERNS + 1) : 1;

  localparam logic [SH_W-1:0] SHIFT_LAST = SH_W'(SCAN_LEN - 1);
  localparam logic [PC_W-1:0] PAT_LAST   = PC_W'(N_PATTERNS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INIT    = 3'd1;
  localparam logic [2:0] SHIFT   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] FLUSH   = 3'd4;
  localparam logic [2:0] COMPARE = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [SH_W-1:0] sh_cnt;
  logic [PC_W-1:0] pat_cnt;
  logic            pass_q;
  logic            in_run;
  logic            abort_req;

`ifdef BIST_ABORT_EN
  assign abort_req = bist_abort;
`else
  assign abort_req = 1'b0;
`endif

  assign in_run = (state == INIT) || (state == SHIFT) || (state == CAPTURE) ||
                  (state == FLUSH) || (state == COMPARE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bist_start) state_nxt = INIT;
      INIT:    state_nxt = SHIFT;
      SHIFT:   if (sh_cnt == SHIFT_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (pat_cnt < PAT_LAST) ? SHIFT : FLUSH;
      FLUSH:   if (sh_cnt == SHIFT_LAST) state_nxt = COMPARE;
      COMPARE: state_nxt = DONE;
      // A start level still held from the previous run must not relaunch it.
      DONE:    if (!bist_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_req && in_run) state_nxt = DONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sh_cnt  <= '0;
      pat_cnt <= '0;
      pass_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        INIT: begin
          sh_cnt  <= '0;
          pat_cnt <= '0;
          pass_q  <= 1'b0;
        end
        SHIFT, FLUSH: begin
          sh_cnt <= (sh_cnt == SHIFT_LAST) ? '0 : sh_cnt + 1'b1;
        end
        CAPTURE: begin
          sh_cnt  <= '0;
          pat_cnt <= pat_cnt + 1'b1;
        end
        COMPARE: begin
          pass_q <= (misr_sig == GOLDEN_SIG);
        end
        DONE: begin
          if (!bist_start) pass_q <= 1'b0;
        end
        default: begin
        end
      endcase
      // An aborted run never reports a pass, even when it aborts out of COMPARE.
      if (abort_req && in_run) pass_q <= 1'b0;
    end
  end

  // Moore outputs: decoded from the registered state only.
  assign prpg_load  = (state == INIT);
  assign misr_clear = (state == INIT);
  assign lfsr_en    = (state == SHIFT);
  assign scan_en    = (state == SHIFT) || (state == FLUSH);
  assign misr_en    = ((state == SHIFT) && (pat_cnt != '0)) || (state == FLUSH);
  assign capture_en = (state == CAPTURE);
  assign bist_mode  = in_run;
  assign bist_busy  = in_run;
  assign bist_end   = (state == DONE);
  assign pass_nfail = pass_q;

endmodule

// File: tb/tb_scan_bist_controller.sv
// Randomized directed bench for scan_bist_controller against a cycle schedule built from the run rules.
// Define BIST_ABORT_EN for both files to also exercise the abort input.
module tb_scan_bist_controller;

  localparam int          SL   = 4;
  localparam int          NP   = 3;
  localparam logic [15:0] GOLD = 16'hA5C3;

  logic        clock;
  logic        reset;
  logic        bist_start;
  logic [15:0] misr_sig;
  logic        prpg_load, misr_clear, lfsr_en, misr_en, scan_en, capture_en;
  logic        bist_mode, bist_busy, bist_end, pass_nfail;
`ifdef BIST_ABORT_EN
  logic        bist_abort;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] sched[$];

  scan_bist_controller #(
    .SCAN_LEN(SL), .N_PATTERNS(NP), .SIG_WIDTH(16), .GOLDEN_SIG(GOLD)
  ) dut (
    .clock(clock), .reset(reset), .bist_start(bist_start),
`ifdef BIST_ABORT_EN
    .bist_abort(bist_abort),
`endif
    .misr_sig(misr_sig), .prpg_load(prpg_load), .misr_clear(misr_clear),
    .lfsr_en(lfsr_en), .misr_en(misr_en), .scan_en(scan_en),
    .capture_en(capture_en), .bist_mode(bist_mode), .bist_busy(bist_busy),
    .bist_end(bist_end), .pass_nfail(pass_nfail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Bit order: prpg_load misr_clear lfsr_en misr_en scan_en capture_en bist_mode bist_busy bist_end pass_nfail
  function automatic logic [9:0] vec(input bit pl, input bit mc, input bit le, input bit me,
                                     input bit se, input bit ce, input bit md, input bit bz,
                                     input bit en, input bit ps);
    return {pl, mc, le, me, se, ce, md, bz, en, ps};
  endfunction

  function automatic logic [9:0] outs();
    return {prpg_load, misr_clear, lfsr_en, misr_en, scan_en, capture_en,
            bist_mode, bist_busy, bist_end, pass_nfail};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected outputs for each cycle from INIT through COMPARE.
  task automatic build_sched();
    sched.delete();
    sched.push_back(vec(1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    for (int p = 0; p < NP; p++) begin
      for (int s = 0; s < SL; s++)
        sched.push_back(vec(0, 0, 1, (p != 0), 1, 0, 1, 1, 0, 0));
      sched.push_back(vec(0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    end
    for (int s = 0; s < SL; s++)
      sched.push_back(vec(0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
    sched.push_back(vec(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
  endtask

  task automatic run_full(input logic [15:0] final_sig, input bit drop_mid);
    int n_pl = 0, n_mc = 0, n_se = 0, n_ce = 0, n_me = 0;
    logic exp_pass;
    logic [9:0] o;
    exp_pass   = (final_sig == GOLD);
    bist_start = 1'b1;
    misr_sig   = 16'($urandom);
    tick();
    for (int i = 0; i < sched.size(); i++) begin
      o = outs();
      chk($sformatf("run_cycle%0d", i), o, sched[i]);
      n_pl += o[9]; n_mc += o[8]; n_me += o[6]; n_se += o[5]; n_ce += o[4];
      if (drop_mid && i == 5) bist_start = 1'b0;
      misr_sig = (i == sched.size() - 1) ? final_sig : 16'($urandom);
      tick();
    end
    misr_sig = 16'($urandom);
    chk("done_entry", outs(), vec(0, 0, 0, 0, 0, 0, 0, 0, 1, exp_pass));
    chk("prpg_load_cycles", n_pl, 1);
    chk("misr_clear_cycles", n_mc, 1);
    chk("scan_en_cycles", n_se, NP * SL + SL);
    chk("capture_pulses", n_ce, NP);
    chk("misr_en_cycles", n_me, (NP - 1) * SL + SL);
  endtask

  initial begin
    logic [15:0] sig;
    bit          drop;
    reset      = 1'b0;
    bist_start = 1'b0;
    misr_sig   = 16'h0;
`ifdef BIST_ABORT_EN
    bist_abort = 1'b0;
`endif
    build_sched();
    #12;
    chk("reset_outs", outs(), 10'h0);
    reset = 1'b1;
    tick();
    chk("idle_outs", outs(), 10'h0);

    // Nominal pass, then held start in DONE must not retrigger.
    run_full(GOLD, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("done_hold", outs(), vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    end
    bist_start = 1'b0;
    tick();
    chk("idle_after_pass", outs(), 10'h0);

    // Single-bit signature miss, immediately followed by a second full run.
    run_full(16'hA5C2, 1'b0);
    bist_start = 1'b0;
    tick();
    chk("idle_after_fail", outs(), 10'h0);
    run_full(GOLD, 1'b0);
    bist_start = 1'b0;
    tick();
    chk("idle_after_rerun", outs(), 10'h0);

    // Randomized runs: signature, mid-run start drop, idle gaps and DONE hold time.
    for (int r = 0; r < 8; r++) begin
      sig  = ($urandom_range(0, 1) == 1) ? GOLD : (GOLD ^ (16'h1 << $urandom_range(0, 15)));
      drop = 1'($urandom_range(0, 1));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        misr_sig = 16'($urandom);
        tick();
        chk("idle_gap", outs(), 10'h0);
      end
      run_full(sig, drop);
      if (!drop) begin
        for (int h = 0; h < int'($urandom_range(1, 5)); h++) begin
          tick();
          chk("rand_done_hold", outs(), vec(0, 0, 0, 0, 0, 0, 0, 0, 1, (sig == GOLD)));
        end
        bist_start = 1'b0;
      end
      tick();
      chk("rand_idle", outs(), 10'h0);
    end

    // Asynchronous reset during the second shift phase.
    bist_start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("pre_reset_shift", outs(), sched[8]);
    #2 reset = 1'b0;
    #1 chk("async_reset_outs", outs(), 10'h0);
    tick();
    chk("reset_held_outs", outs(), 10'h0);
    bist_start = 1'b0;
    reset      = 1'b1;
    tick();
    chk("idle_after_reset", outs(), 10'h0);
    run_full(GOLD, 1'b1);
    tick();
    chk("idle_after_reset_run", outs(), 10'h0);

`ifdef BIST_ABORT_EN
    // Abort in the capture of the second pattern.
    bist_start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("pre_abort_capture", outs(), sched[10]);
    bist_abort = 1'b1;
    tick();
    bist_abort = 1'b0;
    chk("abort_capture_done", outs(), vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    bist_start = 1'b0;
    tick();
    chk("idle_after_abort", outs(), 10'h0);

    // Abort wins over a matching signature in COMPARE.
    bist_start = 1'b1;
    tick();
    for (int i = 0; i < sched.size() - 1; i++) tick();
    chk("pre_abort_compare", outs(), sched[sched.size() - 1]);
    misr_sig   = GOLD;
    bist_abort = 1'b1;
    tick();
    bist_abort = 1'b0;
    chk("abort_compare_done", outs(), vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    bist_start = 1'b0;
    tick();
    chk("idle_after_abort2", outs(), 10'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
